alu_cmd_sequencer: RTL and testbench

//  Upstream issue stage for the 5-bit cep_alu. Accepts one command (op, A, B) per

---
 rtl/alu_cmd_sequencer.sv | 67 ++++++
 tb/tb_alu_cmd_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command at a time to the ALU and returns the settled result over a handshake
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int OPW = 5,
  parameter int RESW = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic            alu_op0,
  output logic            alu_op1,
  input  logic [RESW-1:0] alu_d,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RESW-1:0] res_data,
  output logic [1:0]      res_op,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       accept;
  assign cmd_ready = (state == IDLE) || (state == OUT && res_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = state != IDLE;
  // Sequencer: accept latches operands, WAIT counts down the settle time, OUT holds the result until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op0   <= 1'b0;
      alu_op1   <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_valid <= 1'b0;
    end else begin
      if (state == OUT && res_ready) res_valid <= 1'b0;
      if (accept) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_op0 <= cmd_op[0];
        alu_op1 <= cmd_op[1];
        cnt     <= 4'(SETTLE_CYCLES);
        state   <= WAIT;
      end else if (state == OUT && res_ready) begin
        state <= IDLE;
      end else if (state == WAIT) begin
        if (cnt == 4'd1) begin
          res_data  <= alu_d;
          res_op    <= {alu_op1, alu_op0};
          res_valid <= 1'b1;
          state     <= OUT;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench for alu_cmd_sequencer with a behavioural 5-bit ALU
module tb_alu_cmd_sequencer;
  logic        clk = 0;
  logic        rst = 1;
  logic        cmd_valid = 0, res_ready = 1;
  logic [1:0]  cmd_op = 0;
  logic [4:0]  cmd_a = 0, cmd_b = 0;
  logic        cmd_ready, res_valid, busy, alu_op0, alu_op1;
  logic [4:0]  alu_a, alu_b;
  logic [10:0] alu_d, res_data;
  logic [1:0]  res_op;
  logic        c3_valid = 0;
  logic [4:0]  c3_a = 0, c3_b = 0;
  logic        c3_ready, c3_rvalid, c3_busy, c3_op0, c3_op1;
  logic [4:0]  c3_alu_a, c3_alu_b;
  logic [10:0] c3_d, c3_data;
  logic [1:0]  c3_rop;
  int tests = 0, fails = 0, cyc = 0;
  logic [12:0] sb[$];
  int stamps[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] alu(input logic [4:0] a, input logic [4:0] b, input logic o1, input logic o0);
    logic [10:0] za, zb, d;
    za = {6'b0, a};
    zb = {6'b0, b};
    d = za - zb;
    return o1 ? za * zb : o0 ? {6'b0, d[4:0]} : za + zb;
  endfunction
  assign alu_d = alu(alu_a, alu_b, alu_op1, alu_op0);
  assign c3_d  = alu(c3_alu_a, c3_alu_b, c3_op1, c3_op0);

  alu_cmd_sequencer #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b), .alu_op0(alu_op0),
    .alu_op1(alu_op1), .alu_d(alu_d), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .busy(busy));

  alu_cmd_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_op(2'b00),
    .cmd_a(c3_a), .cmd_b(c3_b), .alu_a(c3_alu_a), .alu_b(c3_alu_b), .alu_op0(c3_op0),
    .alu_op1(c3_op1), .alu_d(c3_d), .res_valid(c3_rvalid), .res_ready(1'b1),
    .res_data(c3_data), .res_op(c3_rop), .busy(c3_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // issue one command and return right after the accepting edge
  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [10:0] exp, input bit track);
    int n = 0;
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    if (track) sb.push_back({op, exp});
    while (!cmd_ready && n < 20) begin tick; n++; end
    if (n >= 20) chk("accept_timeout", 0, 1);
    tick;
    cmd_valid = 0;
  endtask

  // monitor: every consumed result is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      stamps.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_result", {21'b0, res_data}, 0);
      else chk("sb_result", {19'b0, res_op, res_data}, {19'b0, sb.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  vop[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [4:0]  va[4]  = '{5'd1, 5'd20, 5'd7, 5'd15};
    logic [4:0]  vb[4]  = '{5'd2, 5'd4, 5'd6, 5'd16};
    logic [10:0] vd[4]  = '{11'd3, 11'd16, 11'd42, 11'd31};
    int n0;
    tick; tick;
    rst = 0;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_data", res_data, 0);
    // add 31+31
    send(2'b00, 5'd31, 5'd31, 11'h03E, 1);
    chk("wait_cmd_ready", cmd_ready, 0);
    chk("wait_busy", busy, 1);
    chk("wait_res_valid", res_valid, 0);
    chk("alu_a_latched", alu_a, 31);
    tick;
    chk("add_res_valid", res_valid, 1);
    chk("add_res_data", res_data, 11'h03E);
    tick;
    chk("add_consumed", res_valid, 0);
    chk("idle_busy", busy, 0);
    chk("alu_a_held", alu_a, 31);
    // mul 31*31, sub 9-5, op=11 also multiplies
    send(2'b10, 5'd31, 5'd31, 11'h3C1, 1);
    chk("mul_op1", alu_op1, 1);
    chk("mul_op0", alu_op0, 0);
    tick; tick;
    send(2'b01, 5'd9, 5'd5, 11'h004, 1);
    tick; tick;
    send(2'b11, 5'd3, 5'd5, 11'd15, 1);
    tick; tick;
    // backpressure
    res_ready = 0;
    send(2'b00, 5'd10, 5'd7, 11'd17, 1);
    tick;
    chk("bp_valid_first", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 17);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    res_ready = 1;
    tick;
    chk("bp_release", res_valid, 0);
    // back-to-back
    n0 = stamps.size();
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      cmd_valid = 1; cmd_op = vop[i]; cmd_a = va[i]; cmd_b = vb[i];
      sb.push_back({vop[i], vd[i]});
      while (!cmd_ready && n < 20) begin tick; n++; end
      if (i > 0) chk("b2b_accept_in_out", res_valid, 1);
      tick;
    end
    cmd_valid = 0;
    tick; tick;
    chk("b2b_count", stamps.size(), n0 + 4);
    if (stamps.size() == n0 + 4)
      for (int i = 1; i < 4; i++) chk("b2b_spacing", stamps[n0+i] - stamps[n0+i-1], 2);
    // reset during WAIT drops the command
    send(2'b10, 5'd5, 5'd5, 11'd25, 0);
    chk("drop_in_wait", busy, 1);
    rst = 1;
    tick;
    rst = 0;
    chk("rst2_alu_a", alu_a, 0);
    chk("rst2_alu_b", alu_b, 0);
    chk("rst2_ops", {alu_op1, alu_op0}, 0);
    chk("rst2_res_valid", res_valid, 0);
    chk("rst2_res_data", res_data, 0);
    chk("rst2_res_op", res_op, 0);
    chk("rst2_busy", busy, 0);
    repeat (4) tick;
    chk("rst2_no_result", res_valid, 0);
    // SETTLE=3 instance
    c3_valid = 1; c3_a = 6; c3_b = 7;
    chk("s3_idle_ready", c3_ready, 1);
    tick;
    c3_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("s3_wait_ready", c3_ready, 0);
      chk("s3_wait_valid", c3_rvalid, 0);
      tick;
    end
    chk("s3_valid", c3_rvalid, 1);
    chk("s3_data", c3_data, 13);
    tick;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
